// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, FSM states, ALU-op encoding and decode helpers
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [1:0] SEL_IMEM = 2'd0;
  localparam logic [1:0] SEL_DMEM = 2'd1;
  localparam logic [1:0] SEL_RF   = 2'd2;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} aluop_t;
  function automatic logic supported(input logic [5:0] op, input logic [5:0] funct);
    return op == OP_RTYPE ? funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL}
                          : op inside {OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_J};
  endfunction
  function automatic aluop_t alu_sel(input logic [5:0] op, input logic [5:0] funct);
    return op == OP_RTYPE ? (funct == F_SUB ? ALU_SUB : funct == F_AND ? ALU_AND :
                             funct == F_OR  ? ALU_OR  : funct == F_SLT ? ALU_SLT :
                             funct == F_SLL ? ALU_SLL : funct == F_SRL ? ALU_SRL : ALU_ADD)
         : op == OP_BEQ ? ALU_SUB : op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD;
  endfunction
endpackage

// File: rtl/mips_multicycle_if.sv
// mips_multicycle_if: preload port and observation outputs of the multicycle core
interface mips_multicycle_if #(parameter int INIT_AW = 8);
  logic init;
  logic [1:0] init_sel;
  logic [INIT_AW-1:0] init_addr;
  logic [31:0] init_data;
  logic [31:0] aluresultout;
  logic [31:0] shiftresultout;
  logic [31:0] GP_DATA_INout;
  logic halted;
  modport master (output init, init_sel, init_addr, init_data,
                  input aluresultout, shiftresultout, GP_DATA_INout, halted);
  modport slave (input init, init_sel, init_addr, init_data,
                 output aluresultout, shiftresultout, GP_DATA_INout, halted);
endinterface

// File: rtl/mips_alu.sv
// mips_alu: combinational ALU and barrel shifter, 32-bit wrap-around, signed slt
module mips_alu
  import mips_pkg::*;
(
  input logic [31:0] a,
  input logic [31:0] b,
  input logic [4:0] shamt,
  input aluop_t aluop,
  output logic [31:0] result,
  output logic zero
);
  always_comb begin
    result = aluop == ALU_ADD ? a + b :
             aluop == ALU_SUB ? a - b :
             aluop == ALU_AND ? a & b :
             aluop == ALU_OR  ? a | b :
             aluop == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} :
             aluop == ALU_SLL ? b << shamt : b >> shamt;
    zero = result == 32'd0;
  end
endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: FETCH/DECODE/EXEC/MEM/WB/HALT MIPS subset core with a preload port
module mips_multicycle
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int INIT_AW = 8
) (
  input logic clk,
  input logic reset,
  mips_multicycle_if.slave bus
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  state_t state;
  aluop_t aluop;
  logic [31:0] pc, ir, a, b, aluout, mdr;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf [32];
  logic [INIT_AW-1:0] iaddr;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, wb_dst;
  logic [31:0] simm, alu_b, alu_res, rd_a, rd_b, wb_data;
  logic alu_zero, is_r, is_shift;
  assign iaddr = bus.init_addr;
  assign bus.halted = state == S_HALT;
  always_comb begin
    opcode = ir[31:26];
    funct = ir[5:0];
    rs = ir[25:21];
    rt = ir[20:16];
    rd = ir[15:11];
    simm = {{16{ir[15]}}, ir[15:0]};
    is_r = opcode == OP_RTYPE;
    aluop = alu_sel(opcode, funct);
    is_shift = aluop inside {ALU_SLL, ALU_SRL};
    alu_b = (is_r || opcode == OP_BEQ) ? b :
            (opcode == OP_ANDI || opcode == OP_ORI) ? {16'd0, ir[15:0]} : simm;
    rd_a = rs == 5'd0 ? 32'd0 : rf[rs];
    rd_b = rt == 5'd0 ? 32'd0 : rf[rt];
    wb_dst = is_r ? rd : rt;
    wb_data = opcode == OP_LW ? mdr : aluout;
  end
  mips_alu u_alu (
    .a(a),
    .b(alu_b),
    .shamt(ir[10:6]),
    .aluop(aluop),
    .result(alu_res),
    .zero(alu_zero)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      aluout <= '0;
      mdr <= '0;
      bus.aluresultout <= '0;
      bus.shiftresultout <= '0;
      bus.GP_DATA_INout <= '0;
    end else if (!bus.init) begin
      case (state)
        S_FETCH: begin
          ir <= imem[pc[IW+1:2]];
          pc <= pc + 32'd4;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rd_a;
          b <= rd_b;
          state <= supported(opcode, funct) ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          // branches use the ALU only for the zero flag; ALUOut keeps the last data result
          if (opcode == OP_BEQ) begin
            if (alu_zero) pc <= pc + {simm[29:0], 2'b00};
          end else if (opcode == OP_J) begin
            pc <= {pc[31:28], ir[25:0], 2'b00};
          end else begin
            aluout <= alu_res;
            bus.aluresultout <= alu_res;
            if (is_shift) bus.shiftresultout <= alu_res;
          end
          state <= (opcode inside {OP_BEQ, OP_J}) ? S_FETCH :
                   (opcode inside {OP_LW, OP_SW}) ? S_MEM : S_WB;
        end
        S_MEM: begin
          mdr <= dmem[aluout[DW+1:2]];
          state <= opcode == OP_LW ? S_WB : S_FETCH;
        end
        S_WB: begin
          bus.GP_DATA_INout <= wb_data;
          state <= S_FETCH;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (bus.init && bus.init_sel == SEL_IMEM) imem[iaddr[IW-1:0]] <= bus.init_data;
  end
  // a reset mid-instruction forces state to FETCH asynchronously, so no MEM/WB write follows
  always_ff @(posedge clk) begin
    if (bus.init) begin
      if (bus.init_sel == SEL_DMEM) dmem[iaddr[DW-1:0]] <= bus.init_data;
    end else if (state == S_MEM && opcode == OP_SW) begin
      dmem[aluout[DW+1:2]] <= b;
    end
  end
  always_ff @(posedge clk) begin
    if (bus.init) begin
      if (bus.init_sel == SEL_RF && iaddr[4:0] != 5'd0) rf[iaddr[4:0]] <= bus.init_data;
    end else if (state == S_WB && wb_dst != 5'd0) begin
      rf[wb_dst] <= wb_data;
    end
  end
endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, meaning instruction-memory words (power of two).
REQ-002 SHALL have parameter DMEM_DEPTH, default 256, meaning data-memory words (power of two).
REQ-003 SHALL have parameter INIT_AW, default 8, meaning init address width; it SHALL be at least log2 of the larger depth.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port init, input, 1, meaning preload enable; while high, the core is stalled.
REQ-007 SHALL have port init_sel, input, 2, meaning preload target: 0 = imem, 1 = dmem, 2 = register file, 3 = ignored.
REQ-008 SHALL have port init_addr, input, INIT_AW, meaning word index for the preload.
REQ-009 SHALL have port init_data, input, 32, meaning preload data.
REQ-010 SHALL have port aluresultout, output, 32, meaning the registered ALU result.
REQ-011 SHALL have port shiftresultout, output, 32, meaning the registered shifter result.
REQ-012 SHALL have port GP_DATA_INout, output, 32, meaning the last register-file write data.
REQ-013 SHALL have port halted, output, 1, meaning the core is in HALT.

Function
REQ-014 SHALL implement a multicycle FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: IR <= imem[PC>>2]; PC <= PC+4.
- DECODE: A/B <= rs/rt.
- EXEC: ALU/shift operate; ALUOut is registered.
- MEM: lw/sw only.
- WB: register-file write.
REQ-015 SHALL use these cycle counts:
- R-type, addi, andi, ori: 4 cycles (FETCH, DECODE, EXEC, WB).
- lw: 5 cycles (FETCH, DECODE, EXEC, MEM, WB).
- sw: 4 cycles (FETCH, DECODE, EXEC, MEM).
- beq, j: 3 cycles (FETCH, DECODE, EXEC).
REQ-016 SHALL support:
- add, sub, and, or, slt, sll, srl.
- lw, sw, addi (sign-extended), andi/ori (zero-extended).
- beq (target PC+4+(simm<<2)), j (target {PC[31:28], idx, 2'b00}).
REQ-017 SHALL enter HALT on opcode 6'b111111 or any unsupported opcode/funct, and SHALL stay in HALT until reset.
REQ-018 SHALL use 32-bit wrap-around arithmetic with no overflow trap; slt SHALL be a signed compare.
REQ-019 SHALL hardwire register $0 to zero: writes to it are discarded and reads return 0.
REQ-020 SHALL index memories as addr[log2(DEPTH)+1:2]; out-of-range addresses wrap modulo depth.
REQ-021 SHALL freeze FSM, PC and outputs while init is high, and SHALL perform exactly one preload write per cycle.
REQ-022 SHALL resume from FETCH after init falls, with PC unchanged.
REQ-023 SHALL assert halted combinationally from the state register.

Reset
REQ-024 SHALL, on reset low, immediately clear:
- PC, IR, A, B, ALUOut, MDR, aluresultout, shiftresultout, GP_DATA_INout to 0.
- state to FETCH, so halted = 0.
REQ-025 SHALL NOT clear memory and register-file contents on reset.
REQ-026 SHALL, if reset is asserted mid-instruction, abandon that instruction and leave no partial register or memory write.

Structure
REQ-027 SHALL take the following from shared package mips_pkg:
- opcode and funct constants.
- the state enum.
- the ALU-op encoding.
REQ-028 SHALL place the combinational ALU/shifter in sub-module mips_alu (inputs a, b, shamt, aluop; outputs result, zero).

Verification
REQ-029 SHALL cover: preload $1=5, $2=7, imem[0] = add $3,$1,$2 -> after 4 cycles $3=12, GP_DATA_INout=12.
REQ-030 SHALL cover: sw $3,8($0) then lw $4,8($0) -> dmem[2]=12, $4=12; lw takes exactly 5 cycles.
REQ-031 SHALL cover: beq $1,$1,-1 -> PC returns to the same address every 3 cycles; halted stays 0.
REQ-032 SHALL cover: addi $0,$0,9 -> $0 reads 0; instruction 0xFC000000 -> halted=1 and PC frozen.
REQ-033 SHALL cover: reset low during the MEM cycle of sw -> target dmem word unchanged, PC=0, state FETCH.
REQ-034 SHALL cover: sll $5,$1,4 with $1=5 -> shiftresultout=80; slt with 0xFFFFFFFF vs 1 -> 1.
